// File: rtl/pon_frame_pkg.sv
// Shared types and constants for the PON downstream framer and its scrambler.
package pon_frame_pkg;

  // Position within a frame: two PSync words, the superframe counter, then payload.
  typedef enum logic [1:0] {
    ST_HDR0 = 2'd0,
    ST_HDR1 = 2'd1,
    ST_SFC  = 2'd2,
    ST_PAY  = 2'd3
  } frame_state_t;

  localparam logic [31:0] PSYNC_HI_DEF  = 32'hC5E51840;
  localparam logic [31:0] PSYNC_LO_DEF  = 32'hFD59BB49;
  localparam logic [31:0] IDLE_WORD_DEF = 32'h55555555;

  // LFSR seed used by the scrambler and descrambler; reloaded on every header word.
  localparam logic [15:0] SCRAM_SEED = 16'hDEAD;

endpackage

// File: rtl/pon_frame_builder.sv
// Downstream PON transmit framer: PSync header, superframe counter, then a
// fixed number of payload words pulled from a valid/ready source, with idle
// fill on underrun. Drives the scrambler control and header/sof flags.
module pon_frame_builder
  import pon_frame_pkg::*;
#(
  parameter int          PAYLOAD_WORDS = 8,
  parameter logic [31:0] PSYNC_HI      = PSYNC_HI_DEF,
  parameter logic [31:0] PSYNC_LO      = PSYNC_LO_DEF,
  parameter logic [31:0] IDLE_WORD     = IDLE_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] frame_data,
  output logic        scram_en,
  output logic        scram_rst,
  output logic        hdr_flag,
  output logic        sof,
  output logic [15:0] idle_cnt
);

  localparam logic [15:0] LAST_WORD = 16'(PAYLOAD_WORDS - 1);

  frame_state_t state_reg, state_next;
  logic [15:0]  word_cnt_reg, word_cnt_next;
  logic [31:0]  sfc_reg, sfc_next;
  logic [31:0]  frame_data_reg, frame_data_next;
  logic         scram_en_reg, scram_en_next;
  logic         scram_rst_reg, scram_rst_next;
  logic         hdr_flag_reg, hdr_flag_next;
  logic         sof_reg, sof_next;
  logic [15:0]  idle_cnt_reg, idle_cnt_next;

  // Source is only drained on payload slots that the line actually takes.
  assign in_ready = (state_reg == ST_PAY) && tx_en;

  // Next-state and next-output decode; nothing advances without tx_en.
  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    sfc_next        = sfc_reg;
    frame_data_next = frame_data_reg;
    scram_en_next   = 1'b0;
    scram_rst_next  = 1'b0;
    hdr_flag_next   = 1'b0;
    sof_next        = 1'b0;
    idle_cnt_next   = idle_cnt_reg;
    if (tx_en) begin
      scram_en_next = 1'b1;
      unique case (state_reg)
        ST_HDR0: begin
          frame_data_next = PSYNC_HI;
          sof_next        = 1'b1;
          hdr_flag_next   = 1'b1;
          scram_rst_next  = 1'b1;
          state_next      = ST_HDR1;
        end
        ST_HDR1: begin
          frame_data_next = PSYNC_LO;
          hdr_flag_next   = 1'b1;
          scram_rst_next  = 1'b1;
          state_next      = ST_SFC;
        end
        ST_SFC: begin
          frame_data_next = sfc_reg;
          hdr_flag_next   = 1'b1;
          scram_rst_next  = 1'b1;
          state_next      = ST_PAY;
        end
        ST_PAY: begin
          if (in_valid) begin
            frame_data_next = in_data;
          end else begin
            frame_data_next = IDLE_WORD;
            if (idle_cnt_reg != 16'hFFFF) idle_cnt_next = idle_cnt_reg + 16'd1;
          end
          if (word_cnt_reg == LAST_WORD) begin
            word_cnt_next = 16'd0;
            sfc_next      = sfc_reg + 32'd1;
            state_next    = ST_HDR0;
          end else begin
            word_cnt_next = word_cnt_reg + 16'd1;
          end
        end
        default: state_next = ST_HDR0;
      endcase
    end
  end

  // State, counters and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_HDR0;
      word_cnt_reg   <= 16'd0;
      sfc_reg        <= 32'd0;
      frame_data_reg <= 32'd0;
      scram_en_reg   <= 1'b0;
      scram_rst_reg  <= 1'b0;
      hdr_flag_reg   <= 1'b0;
      sof_reg        <= 1'b0;
      idle_cnt_reg   <= 16'd0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      sfc_reg        <= sfc_next;
      frame_data_reg <= frame_data_next;
      scram_en_reg   <= scram_en_next;
      scram_rst_reg  <= scram_rst_next;
      hdr_flag_reg   <= hdr_flag_next;
      sof_reg        <= sof_next;
      idle_cnt_reg   <= idle_cnt_next;
    end
  end

  assign frame_data = frame_data_reg;
  assign scram_en   = scram_en_reg;
  assign scram_rst  = scram_rst_reg;
  assign hdr_flag   = hdr_flag_reg;
  assign sof        = sof_reg;
  assign idle_cnt   = idle_cnt_reg;

endmodule

// File: tb/tb_pon_frame_builder.sv
// Scoreboard bench for pon_frame_builder: a frame-position reference model
// predicts each output word; a monitor compares one entry per clock.
module tb_pon_frame_builder;

  localparam int PW = 4;
  localparam int FRAME_LEN = PW + 3;
  localparam logic [31:0] P_HI = 32'hC5E51840;
  localparam logic [31:0] P_LO = 32'hFD59BB49;
  localparam logic [31:0] IDLE = 32'h55555555;

  typedef struct {
    logic [31:0] fd;
    logic        en;
    logic        srst;
    logic        hdr;
    logic        sof;
    logic [15:0] idle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] frame_data;
  logic        scram_en, scram_rst, hdr_flag, sof;
  logic [15:0] idle_cnt;

  int tests = 0;
  int fails = 0;
  int txn = 0;
  exp_t sb[$];

  // Reference model: position within the frame, frame number, running totals.
  int          m_pos = 0;
  logic [31:0] m_sfc = 32'd0;
  int          m_idle = 0;
  logic [31:0] m_last_fd = 32'd0;
  logic [31:0] next_word = 32'd1;

  pon_frame_builder #(.PAYLOAD_WORDS(PW)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .frame_data(frame_data), .scram_en(scram_en),
    .scram_rst(scram_rst), .hdr_flag(hdr_flag), .sof(sof), .idle_cnt(idle_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus at the falling edge and queue its expected result.
  task automatic step(input logic te, input logic iv, input logic [31:0] d);
    exp_t e;
    logic exp_ready;
    tx_en = te; in_valid = iv; in_data = d;
    #1;
    exp_ready = te && (m_pos >= 3);
    tests++;
    if (in_ready !== exp_ready) begin
      fails++;
      $display("FAIL in_ready: got %b expected %b (pos %0d)", in_ready, exp_ready, m_pos);
    end
    e = '{fd: m_last_fd, en: 1'b0, srst: 1'b0, hdr: 1'b0, sof: 1'b0, idle: 16'(m_idle)};
    if (te) begin
      e.en = 1'b1;
      if (m_pos < 3) begin
        e.hdr = 1'b1; e.srst = 1'b1;
        e.fd = (m_pos == 0) ? P_HI : (m_pos == 1) ? P_LO : m_sfc;
        e.sof = (m_pos == 0);
      end else if (iv) begin
        e.fd = d;
      end else begin
        e.fd = IDLE;
        if (m_idle < 65535) m_idle++;
        e.idle = 16'(m_idle);
      end
      m_pos++;
      if (m_pos == FRAME_LEN) begin
        m_pos = 0;
        m_sfc = m_sfc + 32'd1;
      end
    end
    m_last_fd = e.fd;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Source word: advance the sequence only when the DUT takes it.
  task automatic src_step(input logic te, input logic iv);
    logic take;
    take = te && iv && (m_pos >= 3);
    step(te, iv, next_word);
    if (take) next_word = next_word + 32'd1;
  endtask

  // Hold reset for n cycles with the source offering data; nothing may be accepted.
  task automatic apply_reset(input int n);
    exp_t z;
    z = '{fd: 32'd0, en: 1'b0, srst: 1'b0, hdr: 1'b0, sof: 1'b0, idle: 16'd0};
    rst = 1'b1; tx_en = 1'b1; in_valid = 1'b1; in_data = $urandom;
    sb.delete();
    m_pos = 0; m_sfc = 32'd0; m_idle = 0; m_last_fd = 32'd0;
    for (int i = 0; i < n; i++) begin
      #1;
      tests++;
      if (in_ready !== 1'b0 || frame_data !== 32'd0 || idle_cnt !== 16'd0) begin
        fails++;
        $display("FAIL reset_outputs: in_ready=%b fd=%h idle=%0d expected 0", in_ready, frame_data, idle_cnt);
      end
      sb.push_back(z);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // Monitor: every clock the DUT presents a word; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        tests++;
        if (frame_data !== e.fd || scram_en !== e.en || scram_rst !== e.srst ||
            hdr_flag !== e.hdr || sof !== e.sof || idle_cnt !== e.idle) begin
          fails++;
          $display("FAIL word #%0d: got fd=%h en=%b srst=%b hdr=%b sof=%b idle=%0d expected fd=%h en=%b srst=%b hdr=%b sof=%b idle=%0d",
                   txn, frame_data, scram_en, scram_rst, hdr_flag, sof, idle_cnt,
                   e.fd, e.en, e.srst, e.hdr, e.sof, e.idle);
        end else begin
          $display("[MON] word #%0d fd=%h en=%b srst=%b hdr=%b sof=%b idle=%0d ok",
                   txn, frame_data, scram_en, scram_rst, hdr_flag, sof, idle_cnt);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic with a mid-frame reset.
  initial begin
    int guard;
    @(negedge clk);
    apply_reset(3);

    // Continuous line, always-valid source: two full frames plus a bit.
    for (int i = 0; i < 2 * FRAME_LEN + 2; i++) src_step(1'b1, 1'b1);

    // Line slot available every other cycle for a full frame.
    for (int i = 0; i < 2 * FRAME_LEN; i++) src_step((i % 2) == 0, 1'b1);

    // Align to a frame start, then starve payload slots 1 and 2.
    guard = 0;
    while (m_pos != 0 && guard < 50) begin src_step(1'b1, 1'b1); guard++; end
    for (int i = 0; i < 2 * FRAME_LEN; i++) src_step(1'b1, !(m_pos == 4 || m_pos == 5));

    // Randomized line availability and source validity.
    for (int i = 0; i < 250; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);

    // Reset while on payload word 2 with the source still valid.
    guard = 0;
    while (m_pos != 5 && guard < 50) begin src_step(1'b1, 1'b1); guard++; end
    apply_reset(2);
    for (int i = 0; i < FRAME_LEN + 1; i++) src_step(1'b1, 1'b1);

    for (int i = 0; i < 150; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);

    tx_en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() > 1) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left expected at most 1", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
